sca_command_receive: RTL and testbench

- Host-to-SCA path: collects 9 command bytes from the UART receiver into one SCA command frame.
- Presents the frame as parallel fields to the SCA master and issues a single-cycle start strobe once the master is ready.
- Counterpart of the SCA reply sendback path; the byte order mirrors the reply packet, with command in place of error.
- Has an inter-byte timeout so a truncated host frame cannot stall the link.

---
 rtl/sca_cmd_pkg.sv | 27 ++
 rtl/sca_byte_timeout.sv | 29 ++
 rtl/sca_command_receive.sv | 131 +++++++++++++
 tb/tb_sca_command_receive.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sca_cmd_pkg.sv
// Shared definitions for the SCA command receive path and its reply sendback counterpart.
package sca_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COLLECT    = 2'd1,
        WAIT_READY = 2'd2
    } sca_cmd_state_t;

    localparam int unsigned SCA_FRAME_BYTES = 9;
    localparam int unsigned SCA_FRAME_W     = SCA_FRAME_BYTES * 8;

    // Byte positions within a frame; byte 0 is the first byte on the wire.
    localparam int unsigned BYTE_ADDRESS = 0;
    localparam int unsigned BYTE_TRANSID = 1;
    localparam int unsigned BYTE_CHANNEL = 2;
    localparam int unsigned BYTE_COMMAND = 3;
    localparam int unsigned BYTE_LEN     = 4;
    localparam int unsigned BYTE_DATA    = 5;

    // Frame is held MSB-first: byte 0 occupies the top byte lane.
    function automatic logic [7:0] frame_byte(input logic [SCA_FRAME_W-1:0] frame,
                                              input int unsigned idx);
        return frame[(SCA_FRAME_BYTES - 1 - idx) * 8 +: 8];
    endfunction

endpackage

// File: rtl/sca_byte_timeout.sv
// Inter-byte idle counter; 'last' flags that one more idle cycle reaches the limit.
module sca_byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic last
);

    logic [CNT_W-1:0] cnt_q;

    // Idle counter: clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // An idle edge taken while this is set would bring the count to TIMEOUT_CYCLES-1.
    assign last = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/sca_command_receive.sv
// Assembles 9 UART bytes into an SCA command frame and issues it to the SCA master.
module sca_command_receive
    import sca_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    input  logic        sca_ready,
    output logic        tx_start,
    output logic [7:0]  tx_address,
    output logic [7:0]  tx_transID,
    output logic [7:0]  tx_channel,
    output logic [7:0]  tx_command,
    output logic [7:0]  tx_len,
    output logic [31:0] tx_data,
    output logic        cmd_busy,
    output logic        frame_error,
    output logic        rx_overrun
);

    sca_cmd_state_t         state_q, state_d;
    logic [3:0]             count_q, count_d;
    logic [SCA_FRAME_W-1:0] shift_q, shift_d;
    logic                   busy_d, start_d, error_d, overrun_d, load_tx;
    logic                   to_clear, to_enable, to_last;

    sca_byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (to_clear),
        .enable(to_enable),
        .last  (to_last)
    );

    // Counter runs only on idle cycles inside COLLECT and is held at 0 everywhere else.
    assign to_clear  = uart_rx_valid || (state_q != COLLECT);
    assign to_enable = (state_q == COLLECT);

    // Next-state, shift register and output pulse decode.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        busy_d    = cmd_busy;
        start_d   = 1'b0;
        error_d   = 1'b0;
        overrun_d = 1'b0;
        load_tx   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (uart_rx_valid) begin
                    shift_d = {shift_q[SCA_FRAME_W-9:0], uart_rx_data};
                    count_d = 4'd1;
                    busy_d  = 1'b1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                // A byte in the expiry cycle takes priority over the timeout.
                if (uart_rx_valid) begin
                    shift_d = {shift_q[SCA_FRAME_W-9:0], uart_rx_data};
                    if (count_q != 4'(SCA_FRAME_BYTES)) count_d = count_q + 4'd1;
                    if (count_q == 4'(SCA_FRAME_BYTES - 1)) state_d = WAIT_READY;
                end else if (to_last) begin
                    count_d = 4'd0;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            WAIT_READY: begin
                // Frame is frozen here; any incoming byte is lost.
                overrun_d = uart_rx_valid;
                if (sca_ready) begin
                    load_tx = 1'b1;
                    start_d = 1'b1;
                    busy_d  = 1'b0;
                    count_d = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, assembly register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= 4'd0;
            shift_q     <= '0;
            tx_start    <= 1'b0;
            cmd_busy    <= 1'b0;
            frame_error <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_address  <= 8'd0;
            tx_transID  <= 8'd0;
            tx_channel  <= 8'd0;
            tx_command  <= 8'd0;
            tx_len      <= 8'd0;
            tx_data     <= 32'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            tx_start    <= start_d;
            cmd_busy    <= busy_d;
            frame_error <= error_d;
            rx_overrun  <= overrun_d;
            if (load_tx) begin
                tx_address <= frame_byte(shift_q, BYTE_ADDRESS);
                tx_transID <= frame_byte(shift_q, BYTE_TRANSID);
                tx_channel <= frame_byte(shift_q, BYTE_CHANNEL);
                tx_command <= frame_byte(shift_q, BYTE_COMMAND);
                tx_len     <= frame_byte(shift_q, BYTE_LEN);
                tx_data    <= {frame_byte(shift_q, BYTE_DATA),
                               frame_byte(shift_q, BYTE_DATA + 1),
                               frame_byte(shift_q, BYTE_DATA + 2),
                               frame_byte(shift_q, BYTE_DATA + 3)};
            end
        end
    end

endmodule

// File: tb/tb_sca_command_receive.sv
// Directed bench for sca_command_receive with a short timeout.
module tb_sca_command_receive;

    logic        clk;
    logic        rst_n;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        sca_ready;
    logic        tx_start;
    logic [7:0]  tx_address, tx_transID, tx_channel, tx_command, tx_len;
    logic [31:0] tx_data;
    logic        cmd_busy, frame_error, rx_overrun;

    int n_vec = 0;
    int n_err = 0;

    sca_command_receive #(
        .TIMEOUT_CYCLES(16),
        .CNT_W         (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .sca_ready    (sca_ready),
        .tx_start     (tx_start),
        .tx_address   (tx_address),
        .tx_transID   (tx_transID),
        .tx_channel   (tx_channel),
        .tx_command   (tx_command),
        .tx_len       (tx_len),
        .tx_data      (tx_data),
        .cmd_busy     (cmd_busy),
        .frame_error  (frame_error),
        .rx_overrun   (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present nine bytes on consecutive edges; leaves valid low afterwards.
    task automatic send_frame(input logic [71:0] f);
        for (int i = 0; i < 9; i++) begin
            uart_rx_data  = f[71 - 8*i -: 8];
            uart_rx_valid = 1'b1;
            step();
        end
        uart_rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data = 8'h00;
        sca_ready = 1'b0;
        step();
        step();
        n_vec++;
        if ({tx_start, cmd_busy, frame_error, rx_overrun} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags got=%b want=0000",
                     {tx_start, cmd_busy, frame_error, rx_overrun});
        end
        n_vec++;
        if ({tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data} !== 72'h0) begin
            n_err++;
            $display("FAIL reset_fields got=%h want=0",
                     {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [71:0] f;
        f = 72'h01_02_03_04_05_AA_BB_CC_DD;
        sca_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            uart_rx_data  = f[71 - 8*i -: 8];
            uart_rx_valid = 1'b1;
            step();
            n_vec++;
            if (cmd_busy !== 1'b1 || tx_start !== 1'b0) begin
                n_err++;
                $display("FAIL basic_busy byte=%0d got busy=%b start=%b want busy=1 start=0",
                         i, cmd_busy, tx_start);
            end
        end
        uart_rx_valid = 1'b0;
        step();
        n_vec++;
        if (tx_start !== 1'b1 || cmd_busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_issue got start=%b busy=%b want start=1 busy=0",
                     tx_start, cmd_busy);
        end
        n_vec++;
        if ({tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data} !== f) begin
            n_err++;
            $display("FAIL basic_fields got=%h want=%h",
                     {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data}, f);
        end
        step();
        n_vec++;
        if (tx_start !== 1'b0) begin
            n_err++;
            $display("FAIL basic_single_pulse got start=%b want 0", tx_start);
        end
    endtask

    task automatic test_overrun();
        logic [71:0] f;
        int ov;
        logic exp_ov;
        f = 72'h01_02_03_04_05_AA_BB_CC_DD;
        ov = 0;
        sca_ready = 1'b0;
        send_frame(f);
        for (int c = 1; c <= 20; c++) begin
            exp_ov        = (c == 3) || (c == 7);
            uart_rx_valid = exp_ov;
            uart_rx_data  = (c == 3) ? 8'hEE : 8'hFF;
            step();
            if (rx_overrun === 1'b1) ov++;
            n_vec++;
            if (rx_overrun !== exp_ov || tx_start !== 1'b0 || cmd_busy !== 1'b1) begin
                n_err++;
                $display("FAIL overrun_wait c=%0d got ov=%b start=%b busy=%b want ov=%b start=0 busy=1",
                         c, rx_overrun, tx_start, cmd_busy, exp_ov);
            end
        end
        uart_rx_valid = 1'b0;
        n_vec++;
        if (ov !== 2) begin
            n_err++;
            $display("FAIL overrun_count got=%0d want=2", ov);
        end
        sca_ready = 1'b1;
        step();
        n_vec++;
        if (tx_start !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_issue got start=%b want 1", tx_start);
        end
        n_vec++;
        if ({tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data} !== f) begin
            n_err++;
            $display("FAIL overrun_fields got=%h want=%h",
                     {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data}, f);
        end
        step();
    endtask

    task automatic test_timeout();
        logic [71:0] f;
        f = 72'h21_22_23_24_25_26_27_28_29;
        sca_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uart_rx_data  = 8'h10 + 8'(i);
            uart_rx_valid = 1'b1;
            step();
        end
        uart_rx_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_vec++;
            if (frame_error !== (k == 15) || cmd_busy !== (k < 15) || tx_start !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_idle k=%0d got err=%b busy=%b start=%b want err=%b busy=%b start=0",
                         k, frame_error, cmd_busy, tx_start, (k == 15), (k < 15));
            end
        end
        send_frame(f);
        step();
        n_vec++;
        if (tx_start !== 1'b1 ||
            {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data} !== f) begin
            n_err++;
            $display("FAIL timeout_recover got start=%b fields=%h want start=1 fields=%h",
                     tx_start, {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data}, f);
        end
        step();
    endtask

    task automatic test_expiry_edge();
        logic [71:0] f;
        f = 72'h31_32_33_34_35_36_37_38_39;
        sca_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uart_rx_data  = f[71 - 8*i -: 8];
            uart_rx_valid = 1'b1;
            step();
        end
        uart_rx_valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
        end
        // Fifth byte lands on the edge that would otherwise expire the frame.
        for (int i = 4; i < 9; i++) begin
            uart_rx_data  = f[71 - 8*i -: 8];
            uart_rx_valid = 1'b1;
            step();
            n_vec++;
            if (frame_error !== 1'b0 || cmd_busy !== 1'b1) begin
                n_err++;
                $display("FAIL expiry_byte i=%0d got err=%b busy=%b want err=0 busy=1",
                         i, frame_error, cmd_busy);
            end
        end
        uart_rx_valid = 1'b0;
        step();
        n_vec++;
        if (tx_start !== 1'b1 ||
            {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data} !== f) begin
            n_err++;
            $display("FAIL expiry_issue got start=%b fields=%h want start=1 fields=%h",
                     tx_start, {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data}, f);
        end
        step();
    endtask

    task automatic test_reset_midframe();
        logic [71:0] f;
        f = 72'h61_62_63_64_65_66_67_68_69;
        sca_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            uart_rx_data  = 8'h50 + 8'(i);
            uart_rx_valid = 1'b1;
            step();
        end
        uart_rx_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({tx_start, cmd_busy, frame_error, rx_overrun} !== 4'b0000 ||
            {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data} !== 72'h0) begin
            n_err++;
            $display("FAIL midreset_async got flags=%b fields=%h want 0",
                     {tx_start, cmd_busy, frame_error, rx_overrun},
                     {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_vec++;
        if ({tx_start, cmd_busy, frame_error, rx_overrun} !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset_release got flags=%b want 0000",
                     {tx_start, cmd_busy, frame_error, rx_overrun});
        end
        send_frame(f);
        step();
        n_vec++;
        if (tx_start !== 1'b1 ||
            {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data} !== f) begin
            n_err++;
            $display("FAIL midreset_frame got start=%b fields=%h want start=1 fields=%h",
                     tx_start, {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data}, f);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [71:0] fa, fb;
        fa = 72'h71_72_73_74_75_76_77_78_79;
        fb = 72'h81_82_83_84_85_86_87_88_89;
        sca_ready = 1'b1;
        send_frame(fa);
        step();
        n_vec++;
        if (tx_start !== 1'b1 ||
            {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data} !== fa) begin
            n_err++;
            $display("FAIL b2b_first got start=%b fields=%h want start=1 fields=%h",
                     tx_start, {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data}, fa);
        end
        // First byte of the second frame is presented while tx_start is high.
        send_frame(fb);
        n_vec++;
        if (cmd_busy !== 1'b1 || rx_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_collect got busy=%b ov=%b want busy=1 ov=0", cmd_busy, rx_overrun);
        end
        step();
        n_vec++;
        if (tx_start !== 1'b1 ||
            {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data} !== fb) begin
            n_err++;
            $display("FAIL b2b_second got start=%b fields=%h want start=1 fields=%h",
                     tx_start, {tx_address, tx_transID, tx_channel, tx_command, tx_len, tx_data}, fb);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_timeout();
        test_expiry_edge();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
